// File: rtl/rgb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pkg
//  Brief    : Shared lighting-mode encodings and width helper for rgb_pwm_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
package rgb_pkg;

    localparam logic [1:0] MODE_PASS    = 2'b00;
    localparam logic [1:0] MODE_DIM     = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    // Bits needed to hold values 0..value-1; never returns less than 1.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage : rgb_pkg
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Brief    : One switch channel: 2-FF synchroniser followed by a debouncer
//             that accepts a change after DEB_CYCLES consecutive stable samples.
//  Revision : 1.0 - initial release
// ============================================================================
module sw_debounce
    import rgb_pkg::*;
#(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_sw_db
);

    localparam int                 c_CNT_W  = clog2(DEB_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_TC = c_CNT_W'(DEB_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_db;
    logic [c_CNT_W-1:0] r_cnt;

    // Any sample that agrees with the accepted state restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_db    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_db) begin
                if (r_cnt == c_CNT_TC) begin
                    r_db  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_sw_db = r_db;

endmodule : sw_debounce
`default_nettype wire

// File: rtl/rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rgb_pwm_ctrl
//  Brief    : Debounced switch-to-LED driver with passthrough, dim, blink and
//             breathe modes; mode and effect state change only at PWM wraps.
//  Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_ctrl
    import rgb_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int PWM_W         = 8,
    parameter int DEB_CYCLES    = 1000,
    parameter int DIM_DUTY      = 64,
    parameter int BLINK_PERIODS = 128,
    parameter int BREATHE_STEP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] sw,
    input  logic [1:0]        mode,
    output logic [NUM_CH-1:0] led,
    output logic [NUM_CH-1:0] sw_db,
    output logic              pwm_wrap
);

    localparam logic [PWM_W-1:0] c_PWM_MAX = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] c_DIM     = PWM_W'(DIM_DUTY);
    localparam int               c_BLK_W   = clog2(BLINK_PERIODS + 1);
    localparam logic [c_BLK_W-1:0] c_BLK_TC = c_BLK_W'(BLINK_PERIODS - 1);
    localparam int               c_STP_W   = clog2(BREATHE_STEP + 1);
    localparam logic [c_STP_W-1:0] c_STP_TC = c_STP_W'(BREATHE_STEP - 1);

    logic [NUM_CH-1:0]  w_sw_db;

    logic [PWM_W-1:0]   r_pwm_cnt;
    logic               r_pwm_wrap;
    logic [1:0]         r_mode_q;
    logic [c_BLK_W-1:0] r_blink_cnt;
    logic               r_blink_ph;
    logic [c_STP_W-1:0] r_step_cnt;
    logic [PWM_W-1:0]   r_duty;
    logic               r_dir_up;
    logic [NUM_CH-1:0]  r_led;

    logic [PWM_W-1:0]   w_pwm_next;
    logic               w_at_max;
    logic [1:0]         w_mode_next;
    logic               w_mode_chg;
    logic [c_BLK_W-1:0] w_blink_cnt_next;
    logic               w_blink_ph_next;
    logic [c_STP_W-1:0] w_step_next;
    logic [PWM_W-1:0]   w_duty_next;
    logic               w_dir_up_next;
    logic               w_gate;
    logic [NUM_CH-1:0]  w_led_next;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_sw    (sw[i]),
            .o_sw_db (w_sw_db[i])
        );
    end

    always_comb begin
        w_pwm_next       = r_pwm_cnt + 1'b1;
        w_at_max         = (r_pwm_cnt == c_PWM_MAX);
        w_mode_next      = w_at_max ? mode : r_mode_q;
        w_mode_chg       = w_at_max && (mode != r_mode_q);
        w_blink_cnt_next = r_blink_cnt;
        w_blink_ph_next  = r_blink_ph;
        w_step_next      = r_step_cnt;
        w_duty_next      = r_duty;
        w_dir_up_next    = r_dir_up;

        if (w_mode_chg) begin
            w_blink_cnt_next = '0;
            w_blink_ph_next  = 1'b0;
            w_step_next      = '0;
            w_duty_next      = '0;
            w_dir_up_next    = 1'b1;
        end else if (w_at_max) begin
            if (r_mode_q == MODE_BLINK) begin
                if (r_blink_cnt == c_BLK_TC) begin
                    w_blink_cnt_next = '0;
                    w_blink_ph_next  = ~r_blink_ph;
                end else begin
                    w_blink_cnt_next = r_blink_cnt + 1'b1;
                end
            end
            if (r_mode_q == MODE_BREATHE) begin
                if (r_step_cnt == c_STP_TC) begin
                    w_step_next = '0;
                    if (r_dir_up && (r_duty != c_PWM_MAX)) begin
                        w_duty_next = r_duty + 1'b1;
                    end else if (!r_dir_up && (r_duty != '0)) begin
                        w_duty_next = r_duty - 1'b1;
                    end
                    // Flip as soon as an endpoint is reached so it is held one step only.
                    if (w_duty_next == c_PWM_MAX) begin
                        w_dir_up_next = 1'b0;
                    end else if (w_duty_next == '0) begin
                        w_dir_up_next = 1'b1;
                    end
                end else begin
                    w_step_next = r_step_cnt + 1'b1;
                end
            end
        end
    end

    // Gate uses next-cycle PWM/mode state so the registered LED lines up with pwm_cnt.
    always_comb begin
        w_gate = 1'b0;
        case (w_mode_next)
            MODE_PASS:  w_gate = 1'b1;
            MODE_DIM:   w_gate = (w_pwm_next < c_DIM);
            MODE_BLINK: w_gate = w_blink_ph_next;
            default:    w_gate = (w_pwm_next < w_duty_next);
        endcase
        w_led_next = w_sw_db & {NUM_CH{w_gate}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm_cnt   <= '0;
            r_pwm_wrap  <= 1'b0;
            r_mode_q    <= MODE_PASS;
            r_blink_cnt <= '0;
            r_blink_ph  <= 1'b0;
            r_step_cnt  <= '0;
            r_duty      <= '0;
            r_dir_up    <= 1'b1;
            r_led       <= '0;
        end else begin
            r_pwm_cnt   <= w_pwm_next;
            r_pwm_wrap  <= w_at_max;
            r_mode_q    <= w_mode_next;
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_ph  <= w_blink_ph_next;
            r_step_cnt  <= w_step_next;
            r_duty      <= w_duty_next;
            r_dir_up    <= w_dir_up_next;
            r_led       <= w_led_next;
        end
    end

    assign led      = r_led;
    assign sw_db    = w_sw_db;
    assign pwm_wrap = r_pwm_wrap;

endmodule : rgb_pwm_ctrl
`default_nettype wire

// File: tb/tb_rgb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rgb_pwm_ctrl
//  Brief    : Directed, table-driven bench for rgb_pwm_ctrl (small parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sw  = 3'b000;
    logic [1:0] mode = 2'b00;
    logic [2:0] led;
    logic [2:0] sw_db;
    logic       pwm_wrap;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0]       mode;
        logic [2:0]       sw;
        logic [2:0][15:0] pat;
    } vec_t;

    vec_t vecs [6];

    rgb_pwm_ctrl #(
        .NUM_CH        (3),
        .PWM_W         (4),
        .DEB_CYCLES    (4),
        .DIM_DUTY      (4),
        .BLINK_PERIODS (2),
        .BREATHE_STEP  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .mode     (mode),
        .led      (led),
        .sw_db    (sw_db),
        .pwm_wrap (pwm_wrap)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_wrap(input string nm);
        int n;
        n = 0;
        tick;
        while (!pwm_wrap && n < 20) begin
            tick;
            n++;
        end
        if (!pwm_wrap) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: pwm_wrap not seen within 20 clocks", nm);
        end
    endtask

    // Samples cycles 0..15 of a period and leaves time at cycle 0 of the next.
    task automatic capture(output logic [2:0][15:0] pat);
        pat = '0;
        for (int k = 0; k < 16; k++) begin
            for (int c = 0; c < 3; c++) pat[c][k] = led[c];
            tick;
        end
    endtask

    function automatic int breathe_exp(input int p);
        if (p <= 15) return p;
        else if (p <= 30) return 30 - p;
        else return p - 30;
    endfunction

    initial begin
        logic [2:0][15:0] pat;
        int               exp_led;

        vecs[0] = '{mode: 2'b00, sw: 3'b101, pat: {16'hFFFF, 16'h0000, 16'hFFFF}};
        vecs[1] = '{mode: 2'b00, sw: 3'b010, pat: {16'h0000, 16'hFFFF, 16'h0000}};
        vecs[2] = '{mode: 2'b01, sw: 3'b101, pat: {16'h000F, 16'h0000, 16'h000F}};
        vecs[3] = '{mode: 2'b01, sw: 3'b111, pat: {16'h000F, 16'h000F, 16'h000F}};
        vecs[4] = '{mode: 2'b01, sw: 3'b010, pat: {16'h0000, 16'h000F, 16'h0000}};
        vecs[5] = '{mode: 2'b01, sw: 3'b101, pat: {16'h000F, 16'h0000, 16'h000F}};

        // Reset state
        rst = 1'b1;
        tick;
        tick;
        chk("rst_led", int'(led), 0);
        chk("rst_sw_db", int'(sw_db), 0);
        chk("rst_pwm_wrap", int'(pwm_wrap), 0);
        rst = 1'b0;
        tick;

        // Clean edge on sw[0]: sw_db after 6 clocks, led after 7
        sw[0] = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        chk("deb0_early", int'(sw_db[0]), 0);
        tick;
        chk("deb0_rise", int'(sw_db[0]), 1);
        chk("led0_lag", int'(led[0]), 0);
        tick;
        chk("led0_rise", int'(led[0]), 1);

        // Bouncing sw[1]
        sw[1] = 1'b1; tick;
        sw[1] = 1'b0; tick;
        sw[1] = 1'b1; tick;
        sw[1] = 1'b0; tick;
        sw[1] = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        chk("deb1_early", int'(sw_db[1]), 0);
        tick;
        chk("deb1_rise", int'(sw_db[1]), 1);

        // Static-pattern vectors
        for (int v = 0; v < 6; v++) begin
            sw   = vecs[v].sw;
            mode = vecs[v].mode;
            for (int i = 0; i < 40; i++) tick;
            wait_wrap($sformatf("vec%0d_align", v));
            capture(pat);
            for (int c = 0; c < 3; c++)
                chk($sformatf("vec%0d_led%0d", v, c), int'(pat[c]), int'(vecs[v].pat[c]));
        end

        // DIM -> BLINK mid-period: DIM holds until the wrap
        wait_wrap("mchg_align");
        tick;
        tick;
        mode = 2'b10;
        tick;
        chk("mchg_dim_cnt3", int'(led), 3'b101);
        tick;
        chk("mchg_dim_cnt4", int'(led), 3'b000);
        wait_wrap("blink_align");
        for (int i = 0; i < 96; i++) begin
            if (i > 0) tick;
            exp_led = ((i / 32) % 2 == 1) ? 3'b101 : 3'b000;
            chk($sformatf("blink_t%0d", i), int'(led), exp_led);
            if (i == 32) chk("blink_edge_wrap", int'(pwm_wrap), 1);
        end

        // BREATHE ramp from duty 0
        sw   = 3'b001;
        mode = 2'b11;
        wait_wrap("breathe_align");
        for (int p = 0; p < 32; p++) begin
            capture(pat);
            chk($sformatf("breathe_p%0d", p), $countones(pat[0]), breathe_exp(p));
            chk($sformatf("breathe_p%0d_off", p), int'(pat[1] | pat[2]), 0);
        end

        // Leaving and re-entering BREATHE restarts from duty 0
        mode = 2'b00;
        for (int i = 0; i < 20; i++) tick;
        mode = 2'b11;
        wait_wrap("rebreathe_align");
        for (int p = 0; p < 3; p++) begin
            capture(pat);
            chk($sformatf("rebreathe_p%0d", p), $countones(pat[0]), breathe_exp(p));
        end

        // Asynchronous reset mid-run with all LEDs lit
        mode = 2'b00;
        sw   = 3'b111;
        for (int i = 0; i < 40; i++) tick;
        chk("pre_rst_led", int'(led), 3'b111);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_led", int'(led), 0);
        chk("async_rst_sw_db", int'(sw_db), 0);
        chk("async_rst_wrap", int'(pwm_wrap), 0);
        tick;
        tick;
        chk("hold_rst_all", int'({led, sw_db, pwm_wrap}), 0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick;
            if (i == 5) chk("post_rst_db_early", int'(sw_db), 0);
            if (i == 6) begin
                chk("post_rst_db_rise", int'(sw_db), 3'b111);
                chk("post_rst_led_low", int'(led), 0);
            end
            if (i == 7) chk("post_rst_led_rise", int'(led), 3'b111);
            if (i == 15) chk("post_rst_no_wrap", int'(pwm_wrap), 0);
            if (i == 16) chk("post_rst_first_wrap", int'(pwm_wrap), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rgb_pwm_ctrl
`default_nettype wire
